apb_scratch_timer_top: RTL and testbench
========================================

// Module: apb_scratch_timer_top
// PURPOSE
//  Parametrised APB3 slave for unused peripheral slots. Replaces the tie-off slave, which
//  returns constant data and has no handshake. Provides an ID register, NUM_SCRATCH R/W
//  scratch registers, programmable wait states, PSLVERR on bad accesses, and a countdown
//  timer that raises intr. Sits on the APB bus as a leaf slave behind the APB bridge.
// PARAMETERS
//  ADDR_W       12            decoded paddr bits [ADDR_W-1:0]; upper bits ignored
//  NUM_SCRATCH  4             scratch registers, 1..8, at 0x20+4*i
//  WAIT_CYCLES  0             wait states in access phase, 0..15
//  ID_VALUE     32'h5A5A_0001 value returned by the ID register
//  CNT_W        32            timer width, 1..32; LOAD/COUNT zero-extended on read
// PORTS
//  pclk     in   1   APB clock, the block's only clock
//  presetn  in   1   asynchronous active-low reset
//  psel     in   1   slave select
//  penable  in   1   access phase
//  paddr    in   32  byte address
//  pwrite   in   1   1=write
//  pwdata   in   32  write data
//  pprot    in   3   accepted, ignored
//  prdata   out  32  read data, valid while pready=1 on a read
//  pready   out  1   transfer complete
//  pslverr  out  1   error response, valid while pready=1
//  intr     out  1   level interrupt, registered
// BEHAVIOUR
//  Reset: prdata=0, pready=0, pslverr=0, intr=0, CTRL=0, LOAD=0, COUNT=0, STATUS=0, scratch=0.
//  Map: 0x00 ID(RO); 0x04 CTRL[2:0]={reload,ien,en}; 0x08 LOAD; 0x0C COUNT(RO);
//   0x10 STATUS[0]=pending(W1C); 0x20+4*i SCRATCH[i]; unused data bits read 0.
//  Handshake: a wait counter clears whenever !(psel&penable). pready=1 when psel&penable&wcnt==WAIT_CYCLES.
//   With WAIT_CYCLES=0, pready=1 in the first access cycle. Otherwise wcnt increments each access
//   cycle until it reaches WAIT_CYCLES. pready is 0 outside the access phase.
//  Completion = psel&penable&pready. Writes commit on the completion edge. prdata is combinational
//   from registers during completion and 0 otherwise.
//  pslverr=1 at completion for: unmapped offset, paddr[1:0]!=0, or a write to ID/COUNT.
//   An error write changes no state. An error read returns prdata=0.
//  Timer: writing CTRL with en 0->1 loads COUNT<=LOAD on the next edge.
//   While en=1 and COUNT!=0, COUNT decrements by 1 each cycle.
//   The transition COUNT 1->0 sets pending. If reload=1, COUNT<=LOAD on that same edge instead of 0.
//   With en=1, COUNT=0 and reload=0, the timer holds at 0. en=0 freezes COUNT.
//   Writing LOAD does not disturb a running COUNT.
//  intr <= pending & ien (one-cycle latency from pending).
//  Simultaneous: a W1C to STATUS in the same cycle as an expiry leaves pending=1 (set wins).
//   A CTRL write (en 0->1) together with an expiry: the load takes priority.
//  presetn asserted mid-transfer: all outputs go to reset values asynchronously; the transfer is lost.
//  Timer arithmetic is CNT_W wide with no wrap: decrement is gated at 0.
// STRUCTURE
//  apb_scratch_timer_pkg: register offsets, CTRL bit indices, STATUS bit index.
//  Sub-module apb_scratch_timer_cnt: en/reload/load inputs; COUNT and expire-pulse outputs.
//  Top module holds APB decode, wait counter, registers and the intr flop.
// TESTING
//  1. Reset; read 0x00 -> prdata=32'h5A5A_0001, pslverr=0; all other regs read 0.
//  2. WAIT_CYCLES=3: write 0x20=32'hDEAD_BEEF -> pready rises on the 4th access cycle;
//     readback returns DEAD_BEEF with the same latency.
//  3. Read 0x40 (unmapped), write 0x0C, read 0x22 -> pslverr=1 each time; COUNT unchanged.
//  4. LOAD=5; CTRL=0x3 -> COUNT reads 5,4,..; pending set 5 cycles after the load;
//     intr=1 one cycle later; W1C 0x10=1 -> intr=0.
//  5. LOAD=2, CTRL=0x7 -> expiry every 2 cycles with COUNT reloading.
//     Time a W1C to coincide with an expiry -> pending stays 1.
//  6. Deassert presetn mid access phase with the timer running -> pready, intr and COUNT
//     clear immediately; the next transfer completes normally.

Source files
------------

// File: rtl/apb_scratch_timer_pkg.sv
// rtl/apb_scratch_timer_pkg.sv - register map and field positions for the APB scratch/timer slave
package apb_scratch_timer_pkg;

  localparam logic [7:0] OFF_ID      = 8'h00;
  localparam logic [7:0] OFF_CTRL    = 8'h04;
  localparam logic [7:0] OFF_LOAD    = 8'h08;
  localparam logic [7:0] OFF_COUNT   = 8'h0C;
  localparam logic [7:0] OFF_STATUS  = 8'h10;
  localparam logic [7:0] OFF_SCRATCH = 8'h20;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IEN    = 1;
  localparam int CTRL_RELOAD = 2;

  localparam int STATUS_PEND = 0;

  typedef enum logic [2:0] {
    REG_ID,
    REG_CTRL,
    REG_LOAD,
    REG_COUNT,
    REG_STATUS,
    REG_SCRATCH,
    REG_NONE
  } reg_sel_e;

endpackage

// File: rtl/apb_scratch_timer_cnt.sv
// rtl/apb_scratch_timer_cnt.sv - countdown timer with optional reload and expiry pulse
module apb_scratch_timer_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             reload,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  // start only happens while en is still 0, so it never coincides with a real expiry
  assign expire = en & ~start & (count == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= load_val;
    end else if (en && count != '0) begin
      if (count == CNT_W'(1)) begin
        count <= reload ? load_val : '0;
      end else begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/apb_scratch_timer_top.sv
// rtl/apb_scratch_timer_top.sv - APB3 leaf slave with ID, scratch registers, wait states and timer
module apb_scratch_timer_top
  import apb_scratch_timer_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          NUM_SCRATCH = 4,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h5A5A_0001,
  parameter int          CNT_W       = 32
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  input  logic [2:0]  pprot,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        intr
);

  localparam int         IDX_W    = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
  localparam logic [3:0] WAIT_MAX = 4'(WAIT_CYCLES);

  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  scr_idx;
  logic [3:0]        wcnt;
  logic              access;
  logic              err;
  logic              wr_en;
  logic              load_start;
  reg_sel_e          sel;

  logic [2:0]        ctrl;
  logic [CNT_W-1:0]  load_q;
  logic [CNT_W-1:0]  count;
  logic              expire;
  logic              pend;
  logic [31:0]       scratch [NUM_SCRATCH];

  logic              unused_ok;
  assign unused_ok = ^{pprot, paddr[31:ADDR_W]};

  assign off     = paddr[ADDR_W-1:0];
  assign scr_idx = off[2 +: IDX_W];
  assign access  = psel & penable;

  // Gated by presetn so an asserted reset drops pready immediately, even mid-transfer.
  assign pready = presetn & access & (wcnt == WAIT_MAX);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wcnt <= '0;
    end else if (!access) begin
      wcnt <= '0;
    end else if (wcnt != WAIT_MAX) begin
      wcnt <= wcnt + 4'd1;
    end
  end

  always_comb begin
    sel = REG_NONE;
    if (off[1:0] == 2'b00) begin
      if (off == ADDR_W'(OFF_ID))          sel = REG_ID;
      else if (off == ADDR_W'(OFF_CTRL))   sel = REG_CTRL;
      else if (off == ADDR_W'(OFF_LOAD))   sel = REG_LOAD;
      else if (off == ADDR_W'(OFF_COUNT))  sel = REG_COUNT;
      else if (off == ADDR_W'(OFF_STATUS)) sel = REG_STATUS;
      else if (off[ADDR_W-1:5] == (ADDR_W-5)'(OFF_SCRATCH >> 5) &&
               off[4:2] <= 3'(NUM_SCRATCH - 1)) sel = REG_SCRATCH;
    end
  end

  assign err        = (sel == REG_NONE) | (pwrite & ((sel == REG_ID) | (sel == REG_COUNT)));
  assign wr_en      = pready & pwrite & ~err;
  assign pslverr    = pready & err;
  assign load_start = wr_en & (sel == REG_CTRL) & pwdata[CTRL_EN] & ~ctrl[CTRL_EN];

  always_comb begin
    prdata = '0;
    if (pready && !err) begin
      case (sel)
        REG_ID:      prdata = ID_VALUE;
        REG_CTRL:    prdata = {29'd0, ctrl};
        REG_LOAD:    prdata = 32'(load_q);
        REG_COUNT:   prdata = 32'(count);
        REG_STATUS:  prdata = {31'd0, pend};
        REG_SCRATCH: prdata = scratch[scr_idx];
        default:     prdata = '0;
      endcase
    end
  end

  // Expiry beats a same-cycle W1C so an event is never lost.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl   <= '0;
      load_q <= '0;
      pend   <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else begin
      if (wr_en && sel == REG_CTRL)    ctrl    <= pwdata[2:0];
      if (wr_en && sel == REG_LOAD)    load_q  <= pwdata[CNT_W-1:0];
      if (wr_en && sel == REG_SCRATCH) scratch[scr_idx] <= pwdata;
      if (expire) begin
        pend <= 1'b1;
      end else if (wr_en && sel == REG_STATUS && pwdata[STATUS_PEND]) begin
        pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      intr <= 1'b0;
    end else begin
      intr <= pend & ctrl[CTRL_IEN];
    end
  end

  apb_scratch_timer_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (pclk),
    .rst_n    (presetn),
    .en       (ctrl[CTRL_EN]),
    .reload   (ctrl[CTRL_RELOAD]),
    .start    (load_start),
    .load_val (load_q),
    .count    (count),
    .expire   (expire)
  );

endmodule

// File: tb/tb_apb_scratch_timer_top.sv
// tb/tb_apb_scratch_timer_top.sv - directed bench with per-cycle reference model for the APB scratch/timer slave
module tb_apb_scratch_timer_top;

  localparam int          WAITS = 3;
  localparam int          NSCR  = 4;
  localparam logic [31:0] IDV   = 32'h5A5A_0001;

  logic        pclk    = 1'b0;
  logic        presetn = 1'b1;
  logic        psel    = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [31:0] paddr   = '0;
  logic [31:0] pwdata  = '0;
  logic [2:0]  pprot   = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        intr;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 pclk = ~pclk;

  apb_scratch_timer_top #(
    .ADDR_W      (12),
    .NUM_SCRATCH (NSCR),
    .WAIT_CYCLES (WAITS),
    .ID_VALUE    (IDV),
    .CNT_W       (32)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pprot   (pprot),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .intr    (intr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Reference model: register file as plain variables, addresses as byte offsets.
  logic [2:0]  m_ctrl  = '0;
  logic [31:0] m_load  = '0;
  logic [31:0] m_count = '0;
  logic        m_pend  = 1'b0;
  logic        m_intr  = 1'b0;
  logic [31:0] m_scr [NSCR];
  int          m_acc   = 0;

  function automatic logic m_decode(input logic [31:0] a, input logic w, output logic [31:0] val);
    int   off;
    logic e;
    off = int'(a[11:0]);
    e   = 1'b0;
    val = '0;
    if (off % 4 != 0)                         e = 1'b1;
    else if (off == 0)  begin val = IDV;      e = w; end
    else if (off == 4)  val = {29'd0, m_ctrl};
    else if (off == 8)  val = m_load;
    else if (off == 12) begin val = m_count;  e = w; end
    else if (off == 16) val = {31'd0, m_pend};
    else if (off >= 32 && off < 32 + 4 * NSCR) val = m_scr[(off - 32) / 4];
    else                                      e = 1'b1;
    if (e) val = '0;
    return e;
  endfunction

  always @(posedge pclk or negedge presetn) begin
    logic        e;
    logic [31:0] v;
    logic        wr;
    logic        fired;
    int          off;
    if (!presetn) begin
      m_ctrl  <= '0;
      m_load  <= '0;
      m_count <= '0;
      m_pend  <= 1'b0;
      m_intr  <= 1'b0;
      m_acc   <= 0;
      for (int i = 0; i < NSCR; i++) m_scr[i] <= '0;
    end else begin
      off   = int'(paddr[11:0]);
      e     = m_decode(paddr, pwrite, v);
      wr    = psel && penable && (m_acc == WAITS) && pwrite && !e;
      fired = 1'b0;
      if (wr && off == 4 && pwdata[0] && !m_ctrl[0]) begin
        m_count <= m_load;
      end else if (m_ctrl[0] && m_count > 0) begin
        if (m_count == 1) begin
          fired = 1'b1;
          m_count <= m_ctrl[2] ? m_load : 32'd0;
        end else begin
          m_count <= m_count - 1;
        end
      end
      m_intr <= m_pend && m_ctrl[1];
      if (fired)                            m_pend <= 1'b1;
      else if (wr && off == 16 && pwdata[0]) m_pend <= 1'b0;
      if (wr && off == 4)  m_ctrl <= pwdata[2:0];
      if (wr && off == 8)  m_load <= pwdata;
      if (wr && off >= 32) m_scr[(off - 32) / 4] <= pwdata;
      if (!(psel && penable)) m_acc <= 0;
      else if (m_acc < WAITS) m_acc <= m_acc + 1;
    end
  end

  always @(negedge pclk) begin
    logic        e;
    logic [31:0] v;
    logic        ep;
    #2;
    if (chk_en) begin
      e  = m_decode(paddr, pwrite, v);
      ep = presetn && psel && penable && (m_acc == WAITS);
      chk("cyc_pready",  32'(pready),  32'(ep));
      chk("cyc_intr",    32'(intr),    32'(m_intr));
      chk("cyc_prdata",  prdata,       ep ? v : 32'd0);
      chk("cyc_pslverr", 32'(pslverr), 32'(ep && e));
    end
  end

  task automatic apb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int na);
    bit got;
    got = 1'b0;
    rd  = '0;
    er  = 1'b0;
    na  = 0;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      na++;
      if (pready) begin
        rd  = prdata;
        er  = pslverr;
        got = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL xfer_timeout: addr %h no pready after %0d access cycles", a, na);
    end
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] t1_addr [9] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h20, 32'h24, 32'h28, 32'h2C};
  logic [31:0] t1_exp  [9] = '{32'h5A5A_0001, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    logic [31:0] rd;
    logic        er;
    int          na;
    int          k;

    // reset held with a bus access pending: slave must stay silent
    #3 presetn = 1'b0;
    chk_en = 1'b1;
    psel = 1'b1; penable = 1'b1; paddr = 32'h0;
    repeat (3) @(negedge pclk);
    #1;
    chk("rst_pready",  32'(pready),  32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_prdata",  prdata,       32'd0);
    chk("rst_intr",    32'(intr),    32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apb_xfer(t1_addr[i], 1'b0, 32'h0, rd, er, na);
      chk($sformatf("t1_rd_%h", t1_addr[i]), rd, t1_exp[i]);
      chk($sformatf("t1_err_%h", t1_addr[i]), 32'(er), 32'd0);
    end

    apb_xfer(32'h20, 1'b1, 32'hDEAD_BEEF, rd, er, na);
    chk("t2_wr_latency", 32'(na), 32'd4);
    chk("t2_wr_err", 32'(er), 32'd0);
    apb_xfer(32'h20, 1'b0, 32'h0, rd, er, na);
    chk("t2_rd_latency", 32'(na), 32'd4);
    chk("t2_rd_data", rd, 32'hDEAD_BEEF);
    apb_xfer(32'h2C, 1'b1, 32'h1234_5678, rd, er, na);
    apb_xfer(32'h2C, 1'b0, 32'h0, rd, er, na);
    chk("t2_rd_last_scratch", rd, 32'h1234_5678);
    apb_xfer(32'hFFFF_F020, 1'b0, 32'h0, rd, er, na);
    chk("t2_upper_addr_ignored", rd, 32'hDEAD_BEEF);

    apb_xfer(32'h40, 1'b0, 32'h0, rd, er, na);
    chk("t3_unmapped_err", 32'(er), 32'd1);
    chk("t3_unmapped_data", rd, 32'd0);
    apb_xfer(32'h0C, 1'b1, 32'hFF, rd, er, na);
    chk("t3_wr_count_err", 32'(er), 32'd1);
    apb_xfer(32'h22, 1'b0, 32'h0, rd, er, na);
    chk("t3_misaligned_err", 32'(er), 32'd1);
    apb_xfer(32'h30, 1'b1, 32'h55, rd, er, na);
    chk("t3_scratch_oob_err", 32'(er), 32'd1);
    apb_xfer(32'h00, 1'b1, 32'h77, rd, er, na);
    chk("t3_wr_id_err", 32'(er), 32'd1);
    apb_xfer(32'h0C, 1'b0, 32'h0, rd, er, na);
    chk("t3_count_unchanged", rd, 32'd0);

    apb_xfer(32'h08, 1'b1, 32'd5, rd, er, na);
    apb_xfer(32'h04, 1'b1, 32'h3, rd, er, na);
    for (k = 1; k <= 20; k++) begin
      @(negedge pclk); #1;
      if (intr) break;
    end
    chk("t4_intr_delay", 32'(k), 32'd6);
    apb_xfer(32'h10, 1'b0, 32'h0, rd, er, na);
    chk("t4_status_pend", rd, 32'd1);
    apb_xfer(32'h0C, 1'b0, 32'h0, rd, er, na);
    chk("t4_count_held0", rd, 32'd0);
    apb_xfer(32'h10, 1'b1, 32'h1, rd, er, na);
    #1 chk("t4_intr_after_w1c_edge", 32'(intr), 32'd1);
    @(negedge pclk); #1;
    chk("t4_intr_cleared", 32'(intr), 32'd0);
    apb_xfer(32'h04, 1'b1, 32'h0, rd, er, na);
    apb_xfer(32'h08, 1'b1, 32'd9, rd, er, na);
    apb_xfer(32'h04, 1'b1, 32'h3, rd, er, na);
    apb_xfer(32'h0C, 1'b0, 32'h0, rd, er, na);
    chk("t4_count_midrun", rd, 32'd4);

    apb_xfer(32'h04, 1'b1, 32'h0, rd, er, na);
    apb_xfer(32'h08, 1'b1, 32'd2, rd, er, na);
    apb_xfer(32'h04, 1'b1, 32'h7, rd, er, na);
    apb_xfer(32'h10, 1'b1, 32'h1, rd, er, na);
    @(negedge pclk); #1;
    chk("t5_w1c_on_expiry_keeps_pend", 32'(intr), 32'd1);
    apb_xfer(32'h10, 1'b1, 32'h1, rd, er, na);
    @(negedge pclk); #1;
    chk("t5_w1c_off_expiry_clears", 32'(intr), 32'd0);
    @(negedge pclk); #1;
    chk("t5_next_expiry_sets", 32'(intr), 32'd1);
    apb_xfer(32'h0C, 1'b0, 32'h0, rd, er, na);
    chk("t5_count_reloaded", rd, 32'd2);

    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; paddr = 32'h0; pwrite = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk); #1;
    chk("t6_intr_before_reset", 32'(intr), 32'd1);
    presetn = 1'b0;
    #1;
    chk("t6_pready_async", 32'(pready), 32'd0);
    chk("t6_intr_async",   32'(intr),   32'd0);
    chk("t6_prdata_async", prdata,      32'd0);
    @(negedge pclk);
    presetn = 1'b1; psel = 1'b0; penable = 1'b0;
    apb_xfer(32'h0C, 1'b0, 32'h0, rd, er, na);
    chk("t6_count_cleared", rd, 32'd0);
    apb_xfer(32'h20, 1'b0, 32'h0, rd, er, na);
    chk("t6_scratch_cleared", rd, 32'd0);
    apb_xfer(32'h00, 1'b0, 32'h0, rd, er, na);
    chk("t6_id_after_reset", rd, IDV);
    chk("t6_latency_after_reset", 32'(na), 32'd4);

    @(negedge pclk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
